// File: rtl/sobol_seq_gen_pkg.sv
// Shared constants and direction-vector generation for the Sobol sample generator.
// The vectors are MSB-aligned and are evaluated at elaboration time only.
package sobol_pkg;

  localparam int SOBOL_BITWIDTH = 8;
  localparam int SOBOL_MAX_W    = 16;

  typedef logic [SOBOL_MAX_W-1:0] dirvec_t;
  typedef dirvec_t dirvec_tab_t [2][SOBOL_MAX_W];

  // dim 0: V[k] = 1 << (bw-1-k); dim 1: V[k] = V[k-1] ^ (V[k-1] >> 1)
  function automatic dirvec_t dirvec(input int bw, input logic dim, input int k);
    dirvec_t v;
    v = dirvec_t'(1) << (bw - 1);
    for (int j = 0; j < SOBOL_MAX_W; j++) begin
      if (j < k) begin
        v = dim ? (v ^ (v >> 1)) : (v >> 1);
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/sobol_seq_gen_if.sv
// Enable/clear/count bundle shared with the upstream counter, plus the sample output.
interface sobol_seq_gen_if
  import sobol_pkg::*;
#(
  parameter int BITWIDTH = SOBOL_BITWIDTH
) ();

  logic                iEn;
  logic                iClr;
  logic [BITWIDTH-1:0] iCnt;
  logic                iDim;
  logic [BITWIDTH-1:0] oOut;
  logic                oVld;

  modport master (
    output iEn, iClr, iCnt, iDim,
    input  oOut, oVld
  );

  modport slave (
    input  iEn, iClr, iCnt, iDim,
    output oOut, oVld
  );

endinterface

// File: rtl/sobol_seq_gen_lsz_idx.sv
// Least-significant-zero priority encoder; all_ones flags an all-ones input
// (idx is then 0 and must be ignored).
module lsz_idx #(
  parameter int BITWIDTH = 8,
  parameter int IDXW     = $clog2(BITWIDTH)
) (
  input  logic [BITWIDTH-1:0] cnt,
  output logic [IDXW-1:0]     idx,
  output logic                all_ones
);

  always_comb begin
    idx      = '0;
    all_ones = &cnt;
    // Scan downward so the lowest zero bit is the last one written.
    for (int i = BITWIDTH - 1; i >= 0; i--) begin
      if (!cnt[i]) begin
        idx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/sobol_seq_gen.sv
// Gray-code Sobol generator: x(n+1) = x(n) ^ V[dim][lsz(n)], restarting at 0
// when the upstream counter wraps. One registered sample per enabled cycle.
module sobol_seq_gen
  import sobol_pkg::*;
#(
  parameter int BITWIDTH = SOBOL_BITWIDTH
) (
  input  logic            iClk,
  input  logic            iRstN,
  sobol_seq_gen_if.slave  bus
);

  localparam int IDXW = $clog2(BITWIDTH);

  logic [BITWIDTH-1:0] v_tab [2][BITWIDTH];
  logic [IDXW-1:0]     lsz;
  logic                all_ones;
  logic [BITWIDTH-1:0] v_sel;
  logic [BITWIDTH-1:0] out_reg, out_next;
  logic                vld_reg, vld_next;

  generate
    for (genvar gi = 0; gi < BITWIDTH; gi++) begin : g_dirvec
      assign v_tab[0][gi] = BITWIDTH'(dirvec(BITWIDTH, 1'b0, gi));
      assign v_tab[1][gi] = BITWIDTH'(dirvec(BITWIDTH, 1'b1, gi));
    end
  endgenerate

  lsz_idx #(
    .BITWIDTH (BITWIDTH),
    .IDXW     (IDXW)
  ) u_lsz (
    .cnt      (bus.iCnt),
    .idx      (lsz),
    .all_ones (all_ones)
  );

  assign v_sel = v_tab[bus.iDim][lsz];

  always_comb begin
    out_next = out_reg;
    vld_next = 1'b0;
    if (bus.iClr) begin
      out_next = '0;
    end else if (bus.iEn) begin
      vld_next = 1'b1;
      out_next = all_ones ? '0 : (out_reg ^ v_sel);
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      out_reg <= '0;
      vld_reg <= 1'b0;
    end else begin
      out_reg <= out_next;
      vld_reg <= vld_next;
    end
  end

  assign bus.oOut = out_reg;
  assign bus.oVld = vld_reg;

endmodule
